// File: rtl/stepper_ramp_gen.sv
// Stepper motion front end: accepts a move command and emits step pulses
// along a linear trapezoidal period ramp (accelerate, cruise, decelerate).
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// ACCEL  | period shrinking by RAMP_DELTA per step toward the cruise target
// CRUISE | period held at the target
// DECEL  | period growing back toward START_PERIOD, mirroring the accel phase
// DONE   | one-cycle completion strobe
module stepper_ramp_gen #(
  parameter int CNT_W        = 24,
  parameter int STEP_W       = 16,
  parameter int START_PERIOD = 500000,
  parameter int RAMP_DELTA   = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [CNT_W-1:0]  cmd_period,
  input  logic              stop_req,
  output logic              step_pulse,
  output logic              step_dir,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL, S_DONE} state_t;

  localparam logic [CNT_W-1:0] START_C    = CNT_W'(START_PERIOD);
  localparam logic [CNT_W-1:0] DELTA_C    = CNT_W'(RAMP_DELTA);
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [STEP_W-1:0]  rem_q, rem_d;
  logic [STEP_W-1:0]  ramp_q, ramp_d;
  logic               dir_q, dir_d;
  logic               stop_pend_q, stop_pend_d;

  logic               running;
  logic               pulse;
  logic [CNT_W-1:0]   tgt_in, cur_in, cur_up, cur_dn;
  logic [STEP_W-1:0]  rem_dec;

  assign tgt_in  = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
  assign cur_in  = (START_C > tgt_in) ? START_C : tgt_in;
  assign running = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);
  assign pulse   = running && (timer_q == cur_q - CNT_W'(1));
  assign rem_dec = (rem_q != '0) ? rem_q - STEP_W'(1) : '0;
  // Clamped ramp steps; cur_dn is only used while cur_q > target_q.
  assign cur_up  = (cur_q >= START_C - DELTA_C) ? START_C : cur_q + DELTA_C;
  assign cur_dn  = (cur_q - target_q > DELTA_C) ? cur_q - DELTA_C : target_q;

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign step_pulse = pulse;
  assign step_dir   = dir_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cur_d       = cur_q;
    target_d    = target_q;
    rem_d       = rem_q;
    ramp_d      = ramp_q;
    dir_d       = dir_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dir_d       = cmd_dir;
          rem_d       = cmd_steps;
          target_d    = tgt_in;
          cur_d       = cur_in;
          timer_d     = '0;
          ramp_d      = '0;
          stop_pend_d = 1'b0;
          if (cmd_steps == '0)       state_d = S_DONE;
          else if (cur_in == tgt_in) state_d = S_CRUISE;
          else                       state_d = S_ACCEL;
        end
      end
      S_ACCEL, S_CRUISE, S_DECEL: begin
        if (pulse) begin
          timer_d = '0;
          rem_d   = rem_dec;
          if (stop_req && state_q != S_DECEL) stop_pend_d = 1'b1;
          if (rem_dec == '0) begin
            state_d     = S_DONE;
            stop_pend_d = 1'b0;
          end else if (rem_dec <= ramp_q) begin
            state_d     = S_DECEL;
            cur_d       = cur_up;
            ramp_d      = (ramp_q != '0) ? ramp_q - STEP_W'(1) : '0;
            stop_pend_d = 1'b0;
          end else if (state_q == S_ACCEL && cur_q > target_q) begin
            cur_d  = cur_dn;
            ramp_d = ramp_q + STEP_W'(1);
            if (cur_dn == target_q) state_d = S_CRUISE;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
          // A pending stop turns the rest of the move into a mirrored decel.
          if (state_q != S_DECEL) begin
            if (stop_pend_q) begin
              rem_d       = ramp_q + STEP_W'(1);
              state_d     = S_DECEL;
              stop_pend_d = 1'b0;
            end else if (stop_req) begin
              stop_pend_d = 1'b1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      cur_q       <= '0;
      target_q    <= '0;
      rem_q       <= '0;
      ramp_q      <= '0;
      dir_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cur_q       <= cur_d;
      target_q    <= target_d;
      rem_q       <= rem_d;
      ramp_q      <= ramp_d;
      dir_q       <= dir_d;
      stop_pend_q <= stop_pend_d;
    end
  end

endmodule

// File: tb/tb_stepper_ramp_gen.sv
// Bench for stepper_ramp_gen: directed profiles plus random moves checked
// against an event-level model of the ramp (one iteration per step).
module tb_stepper_ramp_gen;

  localparam int START = 10;
  localparam int DELTA = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [23:0] cmd_period = '0;
  logic        stop_req = 1'b0;
  logic        step_pulse;
  logic        step_dir;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int exp_done;
  int got_q[$];
  int got_done;

  stepper_ramp_gen #(
    .CNT_W(24), .STEP_W(16), .START_PERIOD(START), .RAMP_DELTA(DELTA)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .stop_req(stop_req), .step_pulse(step_pulse), .step_dir(step_dir),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pulse times relative to the accept cycle (cycle 0); stop_c = -1 for none.
  task automatic build_model(input int steps, input int period, input int stop_c);
    int target, cur, rem, ramp, t, nxt;
    bit accel, decel, pend;
    exp_q.delete();
    target = (period < 2) ? 2 : period;
    cur    = (START > target) ? START : target;
    rem    = steps;
    ramp   = 0;
    accel  = (cur != target);
    decel  = 0;
    pend   = 0;
    t      = 0;
    if (steps == 0) begin
      exp_done = 1;
      return;
    end
    while (1) begin
      nxt = t + cur;
      if (!decel && (pend || (stop_c >= t + 1 && stop_c <= nxt - 2))) begin
        rem = ramp + 1; decel = 1; accel = 0; pend = 0;
      end else if (!decel && (stop_c == nxt - 1 || stop_c == nxt)) begin
        pend = 1;
      end
      exp_q.push_back(nxt);
      rem--;
      if (rem == 0) begin
        exp_done = nxt + 1;
        break;
      end else if (rem <= ramp) begin
        decel = 1; accel = 0; pend = 0;
        cur  = (cur + DELTA > START) ? START : cur + DELTA;
        ramp = (ramp > 0) ? ramp - 1 : 0;
      end else if (accel && cur > target) begin
        cur = (cur - DELTA < target) ? target : cur - DELTA;
        ramp++;
        if (cur == target) accel = 0;
      end
      t = nxt;
    end
  endtask

  task automatic run_move(input logic dir, input int steps, input int period,
                          input int stop_c, input string name);
    int c;
    bit busy_ok;
    build_model(steps, period, stop_c);
    got_q.delete();
    got_done = -1;
    busy_ok  = 1;
    c        = 0;
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b expected 1", name, cmd_ready);
    end
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = steps[15:0];
    cmd_period = period[23:0];
    while (got_done < 0 && c < 3000) begin
      @(posedge clk); #1;
      c++;
      cmd_valid = 1'b0;
      if (step_pulse === 1'b1) got_q.push_back(c);
      if (done === 1'b1) got_done = c;
      if (busy !== 1'b1 || step_dir !== dir) busy_ok = 0;
      stop_req = (c == stop_c);
    end
    stop_req = 1'b0;
    n_checks++;
    if (got_done != exp_done) begin
      n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", name, got_done, exp_done);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s pulse_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL %s pulse[%0d]: got cycle %0d expected %0d", name, i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (!busy_ok) begin
      n_fail++; $display("FAIL %s busy_dir: got busy/dir mismatch expected busy=1 dir=%b", name, dir);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s idle_after: got done=%b ready=%b busy=%b expected 0/1/0", name, done, cmd_ready, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || step_pulse !== 1'b0 || done !== 1'b0 || step_dir !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got ready=%b busy=%b pulse=%b done=%b dir=%b expected 1/0/0/0/0",
               cmd_ready, busy, step_pulse, done, step_dir);
    end
    rst = 1'b1;
  endtask

  task automatic test_symmetric;
    int exp_p[5] = '{10, 18, 24, 32, 42};
    run_move(1'b1, 5, 4, -1, "symmetric");
    n_checks++;
    if (got_q.size() != 5) begin
      n_fail++; $display("FAIL symmetric_fixed_count: got %0d expected 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (got_q[i] != exp_p[i]) begin
          n_fail++; $display("FAIL symmetric_fixed[%0d]: got %0d expected %0d", i, got_q[i], exp_p[i]);
        end
      end
    end
    n_checks++;
    if (got_done != 43) begin
      n_fail++; $display("FAIL symmetric_done: got %0d expected 43", got_done);
    end
  endtask

  task automatic test_cruise;
    int exp_p[3] = '{12, 24, 36};
    run_move(1'b0, 3, 12, -1, "cruise");
    n_checks++;
    if (got_q.size() != 3) begin
      n_fail++; $display("FAIL cruise_count: got %0d expected 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_q[i] != exp_p[i]) begin
          n_fail++; $display("FAIL cruise_fixed[%0d]: got %0d expected %0d", i, got_q[i], exp_p[i]);
        end
      end
    end
  endtask

  task automatic test_zero_and_clamp;
    int min_iv;
    run_move(1'b1, 0, 5, -1, "zero_steps");
    n_checks++;
    if (got_q.size() != 0 || got_done != 1) begin
      n_fail++; $display("FAIL zero_steps: got pulses=%0d done=%0d expected 0 and 1", got_q.size(), got_done);
    end
    run_move(1'b0, 20, 0, -1, "clamp");
    min_iv = 1000;
    for (int i = 1; i < got_q.size(); i++)
      if (got_q[i] - got_q[i-1] < min_iv) min_iv = got_q[i] - got_q[i-1];
    n_checks++;
    if (min_iv != 2) begin
      n_fail++; $display("FAIL clamp_interval: got %0d expected 2", min_iv);
    end
  endtask

  task automatic test_stop;
    int after;
    int exp_iv[4] = '{4, 6, 8, 10};
    run_move(1'b1, 100, 4, 30, "stop");
    after = 0;
    foreach (got_q[i]) if (got_q[i] > 30) after++;
    n_checks++;
    if (after != 4 || got_q.size() >= 100) begin
      n_fail++; $display("FAIL stop_pulses_after: got %0d total %0d expected 4", after, got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_q[got_q.size()-4+i] - got_q[got_q.size()-5+i] != exp_iv[i]) begin
          n_fail++;
          $display("FAIL stop_interval[%0d]: got %0d expected %0d", i,
                   got_q[got_q.size()-4+i] - got_q[got_q.size()-5+i], exp_iv[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ready_low_ok = 1;
    bit done_seen = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd2; cmd_period = 24'd10;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        cmd_dir = 1'b0; cmd_steps = 16'd1; cmd_period = 24'd10;
      end
      if (c >= 2 && c <= 21 && cmd_ready !== 1'b0) ready_low_ok = 0;
      if (c == 21) begin
        n_checks++;
        if (done !== 1'b1) begin
          n_fail++; $display("FAIL b2b_first_done: got %b expected 1", done);
        end
      end
      if (c == 22) begin
        n_checks++;
        if (cmd_ready !== 1'b1 || step_dir !== 1'b1) begin
          n_fail++; $display("FAIL b2b_idle: got ready=%b dir=%b expected 1/1", cmd_ready, step_dir);
        end
      end
      if (c == 23) begin
        n_checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || step_dir !== 1'b0) begin
          n_fail++; $display("FAIL b2b_second_accept: got busy=%b ready=%b dir=%b expected 1/0/0", busy, cmd_ready, step_dir);
        end
        cmd_valid = 1'b0;
      end
      if (c == 32) begin
        n_checks++;
        if (step_pulse !== 1'b1) begin
          n_fail++; $display("FAIL b2b_second_pulse: got %b expected 1", step_pulse);
        end
      end
      if (c == 33) begin
        done_seen = (done === 1'b1);
        n_checks++;
        if (!done_seen) begin
          n_fail++; $display("FAIL b2b_second_done: got %b expected 1", done);
        end
      end
    end
    n_checks++;
    if (!ready_low_ok) begin
      n_fail++; $display("FAIL b2b_ready_busy: got ready high while busy expected 0");
    end
  endtask

  task automatic test_reset_mid_move;
    bit quiet = 1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd5; cmd_period = 24'd4;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    n_checks++;
    if (step_pulse !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_pulse: got %b expected 1", step_pulse);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (step_pulse !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || step_dir !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_move: got pulse=%b busy=%b ready=%b dir=%b done=%b expected 0/0/1/0/0",
               step_pulse, busy, cmd_ready, step_dir, done);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (step_pulse !== 1'b0 || done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++; $display("FAIL rst_quiet_after: got activity after reset expected none");
    end
  endtask

  task automatic test_random;
    int steps, period, stop_c;
    logic dir;
    for (int k = 0; k < 12; k++) begin
      steps  = (k % 4 == 3) ? $urandom_range(20, 40) : $urandom_range(0, 12);
      period = $urandom_range(0, 14);
      dir    = 1'($urandom_range(0, 1));
      stop_c = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 80) : -1;
      run_move(dir, steps, period, stop_c, "random");
    end
  endtask

  initial begin
    test_reset();
    test_symmetric();
    test_cruise();
    test_zero_and_clamp();
    test_stop();
    test_back_to_back();
    test_reset_mid_move();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stepper_ramp_gen.md
Name: stepper_ramp_gen

Overview:
- Upstream motion stage for the stepper phase sequencer.
- Accepts a move command (direction, step count, cruise period) over a valid/ready handshake.
- Emits one-cycle step pulses with a linear trapezoidal period ramp: accelerate, cruise, then decelerate symmetrically.
- Downstream, the phase sequencer advances one phase per step_pulse, in the order selected by step_dir.

Parameters:
- CNT_W, 24, width of period and timer registers.
- STEP_W, 16, width of the step-count registers.
- START_PERIOD, 500000, start/stop step period in clk cycles (10 ms at 50 MHz).
- RAMP_DELTA, 2000, period change per step during a ramp.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_dir  in  1  direction, 1 = forward.
- cmd_steps  in  STEP_W  number of steps to issue.
- cmd_period  in  CNT_W  target cruise period in clk cycles.
- stop_req  in  1  request controlled stop.
- step_pulse  out  1  one-cycle step strobe to the phase sequencer.
- step_dir  out  1  direction of the current or last move.
- busy  out  1  move in progress; high in every state except IDLE.
- done  out  1  one-cycle pulse when a move completes.

Behaviour:
- Reset (async, rst=0): state=IDLE, step_pulse=0, step_dir=0, busy=0, done=0, cmd_ready=1. All internal timers and counters are 0, and any pending stop is cleared. Reset mid-move stops pulses immediately; no done pulse is issued.
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.
- Accept: in IDLE, cmd_valid=1 is accepted on that clk edge (call it cycle 0). The block latches:
  - step_dir := cmd_dir
  - remaining := cmd_steps
  - target := max(cmd_period, 2)
  - cur := max(START_PERIOD, target)
  - timer := 0, ramp_steps := 0
- Next state after accept:
  - cmd_steps=0: go to DONE (no pulses).
  - cur==target: go to CRUISE.
  - otherwise: go to ACCEL.
- Timer: in ACCEL/CRUISE/DECEL the timer increments each cycle. When timer == cur-1:
  - step_pulse=1 for that cycle, timer := 0, remaining := remaining-1.
  - Consequence: the first pulse occurs exactly cur cycles after cycle 0, and consecutive pulses are spaced by the cur value in force.
- Ramp update, applied in the pulse cycle, evaluated in priority order using the post-decrement remaining:
  1. remaining==0: go to DONE.
  2. remaining <= ramp_steps: go to DECEL; cur := min(cur+RAMP_DELTA, START_PERIOD); ramp_steps := ramp_steps-1, saturating at 0.
  3. State is ACCEL and cur > target: cur := max(cur-RAMP_DELTA, target); ramp_steps := ramp_steps+1. If the new cur equals target, go to CRUISE.
  4. Otherwise: no change.
- Short moves never reach CRUISE; the profile peaks and then mirrors itself.
- DONE: lasts one cycle with done=1 and busy=1, then returns to IDLE. cmd_ready=0 in DONE.
- Stop handling:
  - stop_req=1 in ACCEL or CRUISE sets stop_pend.
  - In the first non-pulse cycle with stop_pend set: remaining := ramp_steps+1, go to DECEL, clear stop_pend.
  - stop_req is ignored in IDLE, DECEL and DONE.
- Arithmetic: all period arithmetic is unsigned CNT_W with explicit clamps, so there is never wrap-around. remaining never underflows.
- cmd_valid while busy is ignored; the upstream holder keeps it asserted until accepted.

Test Plan:
- Bench parameters: START_PERIOD=10, RAMP_DELTA=2.
- Reset values: hold rst=0 -> cmd_ready=1, busy=0, step_pulse=0, done=0. Assert rst mid-move -> pulses stop the same cycle and no done pulse occurs.
- Symmetric ramp: cmd steps=5, period=4, dir=1 accepted at cycle 0 -> pulses at cycles 10,18,24,32,42 (intervals 10,8,6,8,10); done at cycle 43; IDLE with cmd_ready=1 at cycle 44; step_dir=1 throughout.
- Cruise without ramp: cmd steps=3, period=12 -> pulses every 12 cycles (cycles 12,24,36); state never enters ACCEL.
- Zero steps / clamp: cmd steps=0 -> no pulses, done one cycle after accept. cmd period=0 on a long move -> cruise interval is 2.
- Stop request: cmd steps=100, period=4; pulse stop_req at cycle 30 (cruise, ramp_steps=3) -> exactly 4 further pulses at intervals 4,6,8,10, then done; total pulse count < 100.
- Handshake: hold cmd_valid=1 through a move -> the second command is accepted only on the first IDLE cycle after done, and step_dir updates on that accept.
